// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared Gray-code constants, action type and conversion helpers
package gray_pkg;

    localparam int GRAY_DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_CLR,
        ACT_LOAD,
        ACT_STEP
    } gray_act_e;

    function automatic logic [31:0] bin_to_gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [31:0] gray_to_bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic bit is_one_hot_diff(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d;
        d = a ^ b;
        return (d != 32'd0) && ((d & (d - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/bin2gray_comb.sv
// rtl/bin2gray_comb.sv - combinational binary-to-Gray encoder
module bin2gray_comb #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] g
);

    assign g = b ^ (b >> 1);

endmodule

// File: rtl/gray_counter.sv
// rtl/gray_counter.sv - up/down binary counter with registered glitch-free Gray output
module gray_counter
    import gray_pkg::*;
#(
    parameter int unsigned      WIDTH     = GRAY_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] RESET_GRAY = RESET_VAL ^ (RESET_VAL >> 1);
    localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

    gray_act_e        act;
    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] gray_next;
    logic             wrap_next;

    always_comb begin
        act = ACT_HOLD;
        if (clr) begin
            act = ACT_CLR;
        end else if (load) begin
            act = ACT_LOAD;
        end else if (en) begin
            act = ACT_STEP;
        end
    end

    always_comb begin
        bin_next  = bin;
        wrap_next = 1'b0;
        case (act)
            ACT_CLR:  bin_next = '0;
            ACT_LOAD: bin_next = load_val;
            ACT_STEP: begin
                if (up_dn) begin
                    bin_next  = bin + ONE;
                    wrap_next = &bin;
                end else begin
                    bin_next  = bin - ONE;
                    wrap_next = ~|bin;
                end
            end
            default:  bin_next = bin;
        endcase
    end

    // Gray is encoded from the next-state value and registered alongside bin,
    // so the two outputs can never disagree and gray never glitches.
    bin2gray_comb #(
        .WIDTH(WIDTH)
    ) u_enc (
        .b(bin_next),
        .g(gray_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin  <= RESET_VAL;
            gray <= RESET_GRAY;
            wrap <= 1'b0;
        end else begin
            bin  <= bin_next;
            gray <= gray_next;
            wrap <= wrap_next;
        end
    end

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Registered up/down binary counter that also outputs the Gray-code form of the count from a flop, so the Gray value is glitch-free.
- Provides the encode direction for our Gray-to-binary decoder.
- Drives async-FIFO read/write pointers and encoder-position models. The `gray` output is safe to feed straight into a 2-flop synchroniser in another clock domain.

Parameters:
- WIDTH, 4, counter and Gray width in bits (legal range 2..32).
- RESET_VAL, 0, binary value loaded on reset (must be < 2**WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  advance the count by one step this cycle.
- up_dn  input  1  step direction: 1 = increment, 0 = decrement. Sampled only when en=1.
- clr  input  1  synchronous clear to 0.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  binary value to load.
- bin  output  WIDTH  registered binary count.
- gray  output  WIDTH  registered Gray code of bin.
- wrap  output  1  one-cycle pulse: the last en-step crossed the terminal count.

Behaviour:
- Reset
  - One clock; reset is asynchronous and active-low.
  - rst_n=0 immediately forces bin=RESET_VAL, gray=RESET_VAL^(RESET_VAL>>1), wrap=0, regardless of clk.
  - Deassertion is synchronised by the parent's reset bridge; no internal synchroniser.
- Priority per rising edge: clr > load > en. Only one action occurs per edge.
- clr=1: bin<=0, gray<=0, wrap<=0.
- load=1 (clr=0): bin<=load_val, gray<=load_val^(load_val>>1), wrap<=0.
- en=1 (clr=0, load=0):
  - next = bin+1 if up_dn=1, else bin-1, modulo 2**WIDTH.
  - bin<=next; gray<=next^(next>>1).
  - wrap<=1 if (up_dn=1 and bin=2**WIDTH-1) or (up_dn=0 and bin=0), else 0.
- No action (clr=0, load=0, en=0): bin and gray hold; wrap<=0.
- Gray encoding
  - g[WIDTH-1]=b[WIDTH-1]; g[i]=b[i+1] XOR b[i] for i<WIDTH-1. XOR only, never AND.
  - gray is computed from next-state binary and registered, never decoded combinationally from bin on the output path.
- Latency: bin, gray and wrap all update on the same edge, one cycle after the enabling inputs are sampled. There is no cycle where bin and gray disagree.
- Single-bit-change invariant: across any en-step, including wrap-around in either direction, gray changes in exactly one bit. clr and load may change multiple bits; consumers must not treat those as pointer moves.
- Direction change (up_dn toggling between en-steps) is legal. The step is still one bit in gray.
- en held with load or clr: en is ignored that cycle, and no wrap pulse is produced by a load or clr.
- Reset mid-operation: async reset overrides any in-flight action. The first post-reset edge behaves per the priority rules.
- load_val is assumed valid binary; no range check is needed since all 2**WIDTH values are legal.

Decomposition:
- Package gray_pkg:
  - constant GRAY_DEFAULT_WIDTH=4.
  - function bin_to_gray(b): b^(b>>1).
  - function gray_to_bin(g): prefix XOR from MSB down. This is shared with the decoder and fixes its AND bug.
  - function is_one_hot_diff(a,b) for bench assertions.
- Sub-module bin2gray_comb: pure combinational WIDTH-parameterised encoder, instantiated on the next-state path. The counter/wrap logic stays in gray_counter.

Test Plan:
1. Reset then count up (WIDTH=4, RESET_VAL=0):
   - rst_n 0→1, then en=1, up_dn=1 for 16 cycles.
   - gray sequence: 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000, then 0000.
   - wrap=1 only in the cycle bin returns to 0.
2. Count down through zero from bin=0:
   - en=1, up_dn=0 for one cycle → bin=1111, gray=1000, wrap=1.
   - next step → bin=1110, gray=1001, wrap=0.
3. Load, and load vs clr priority:
   - load=1, load_val=1010 → bin=1010, gray=1111, wrap=0.
   - clr=1, load=1, en=1 in the same cycle → bin=0000, gray=0000.
4. Async reset mid-count with RESET_VAL=5:
   - Drop rst_n between edges at bin=0111 → bin=0101 and gray=0111 before the next clk edge.
   - Counting resumes from 0101 after release.
5. Random en/up_dn/load/clr for 10k cycles at WIDTH=8:
   - gray == bin^(bin>>1) every cycle.
   - Every en-only step changes exactly one gray bit.
   - gray_to_bin(gray) == bin.
